// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed on-chip RAM. The read and write
// channels run independent FSMs, each with one transaction in flight.
module axi_sram_slave #(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int          DEPTH   = 1 << MEM_AW;
  localparam int          TAG_LSB = MEM_AW + 2;
  localparam logic [31:0] BASE    = BASE_ADDR;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // A request the RAM cannot honour still runs its full beat count, just
  // without touching memory and with SLVERR.
  function automatic logic req_err(input logic [31:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic e;
    e = (addr[31:TAG_LSB] != BASE[31:TAG_LSB]);
    if (size != 3'b010) e = 1'b1;
    if (burst == 2'b11) e = 1'b1;
    if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) e = 1'b1;
    if (len > 8'd15) e = 1'b1;
    return e;
  endfunction

  function automatic logic [MEM_AW-1:0] adv(input logic [MEM_AW-1:0] a,
                                            input logic [1:0] burst, input logic [7:0] len);
    logic [MEM_AW-1:0] mask;
    logic [MEM_AW-1:0] inc;
    logic [MEM_AW-1:0] res;
    mask = MEM_AW'(len[3:0]);
    inc  = a + MEM_AW'(1);
    case (burst)
      2'b00:   res = a;
      2'b10:   res = (a & ~mask) | (inc & mask);
      default: res = inc;
    endcase
    return res;
  endfunction

  logic unused_ok;
  assign unused_ok = ^{awlock, awcache, awprot, wid, arlock, arcache, arprot,
                       awaddr[1:0], araddr[1:0]};

  // Holds every output low for the cycle following a sampled reset.
  logic in_rst_q, in_rst_d;
  always_comb in_rst_d = rst;
  always_ff @(posedge clk) in_rst_q <= in_rst_d;

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [3:0]        w_id_q, w_id_d;
  logic [MEM_AW-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic              w_err_q, w_err_d;
  logic              w_last_err_q, w_last_err_d;
  logic [7:0]        w_cnt_q, w_cnt_d;

  logic aw_hs, w_hs, b_hs, w_beat_last;
  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bvalid & bready;
  assign w_beat_last = (w_cnt_q == w_len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      w_id_q       <= '0;
      w_addr_q     <= '0;
      w_len_q      <= '0;
      w_burst_q    <= '0;
      w_err_q      <= 1'b0;
      w_last_err_q <= 1'b0;
      w_cnt_q      <= '0;
    end else begin
      w_state_q    <= w_state_d;
      w_id_q       <= w_id_d;
      w_addr_q     <= w_addr_d;
      w_len_q      <= w_len_d;
      w_burst_q    <= w_burst_d;
      w_err_q      <= w_err_d;
      w_last_err_q <= w_last_err_d;
      w_cnt_q      <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d    = w_state_q;
    w_id_d       = w_id_q;
    w_addr_d     = w_addr_q;
    w_len_d      = w_len_q;
    w_burst_d    = w_burst_q;
    w_err_d      = w_err_q;
    w_last_err_d = w_last_err_q;
    w_cnt_d      = w_cnt_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        w_state_d    = W_DATA;
        w_id_d       = awid;
        w_addr_d     = awaddr[TAG_LSB-1:2];
        w_len_d      = awlen;
        w_burst_d    = awburst;
        w_err_d      = req_err(awaddr, awlen, awsize, awburst);
        w_last_err_d = 1'b0;
        w_cnt_d      = '0;
      end
      W_DATA: if (w_hs) begin
        // The beat counter, not wlast, ends the burst; disagreement is reported.
        w_addr_d = adv(w_addr_q, w_burst_q, w_len_q);
        w_cnt_d  = w_cnt_q + 8'd1;
        if (wlast != w_beat_last) w_last_err_d = 1'b1;
        if (w_beat_last) w_state_d = W_RESP;
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = 2'b00;
    if (!in_rst_q) begin
      case (w_state_q)
        W_IDLE: awready = 1'b1;
        W_DATA: wready  = 1'b1;
        W_RESP: begin
          bvalid = 1'b1;
          bid    = w_id_q;
          bresp  = (w_err_q || w_last_err_q) ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  // ---------------- RAM ----------------
  logic [31:0] mem [DEPTH];
  logic [3:0]  lane_we;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = w_hs & ~w_err_q & wstrb[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) mem[w_addr_q][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [3:0]        r_id_q, r_id_d;
  logic [MEM_AW-1:0] r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic              r_err_q, r_err_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic [31:0]       rd_word_q;
  logic              rd_en;

  logic ar_hs, r_hs, r_beat_last;
  assign ar_hs       = arvalid & arready;
  assign r_hs        = rvalid & rready;
  assign r_beat_last = (r_cnt_q == r_len_q);

  // The RAM output register only loads when a new beat is due, so a stalled
  // beat keeps its data even if the same word is written meanwhile.
  assign rd_en = ar_hs | (r_hs & ~r_beat_last);

  always_ff @(posedge clk) begin
    if (rd_en) rd_word_q <= mem[r_addr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    r_cnt_d   = r_cnt_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_DATA;
        r_id_d    = arid;
        r_addr_d  = araddr[TAG_LSB-1:2];
        r_len_d   = arlen;
        r_burst_d = arburst;
        r_err_d   = req_err(araddr, arlen, arsize, arburst);
        r_cnt_d   = '0;
      end
      R_DATA: if (r_hs) begin
        if (r_beat_last) begin
          r_state_d = R_IDLE;
        end else begin
          r_addr_d = adv(r_addr_q, r_burst_q, r_len_q);
          r_cnt_d  = r_cnt_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    if (!in_rst_q) begin
      case (r_state_q)
        R_IDLE: arready = 1'b1;
        R_DATA: begin
          rvalid = 1'b1;
          rid    = r_id_q;
          rdata  = r_err_q ? 32'h0 : rd_word_q;
          rresp  = r_err_q ? 2'b10 : 2'b00;
          rlast  = r_beat_last;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a table of single-beat write/read pairs
// followed by hand-written multi-beat, error, backpressure and reset sequences.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;    logic [31:0] awaddr;  logic [7:0] awlen;
  logic [2:0]  awsize;  logic [1:0]  awburst; logic [1:0] awlock;
  logic [3:0]  awcache; logic [2:0]  awprot;  logic awvalid, awready;
  logic [3:0]  wid;     logic [31:0] wdata;   logic [3:0] wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;     logic [1:0]  bresp;   logic bvalid, bready;
  logic [3:0]  arid;    logic [31:0] araddr;  logic [7:0] arlen;
  logic [2:0]  arsize;  logic [1:0]  arburst; logic [1:0] arlock;
  logic [3:0]  arcache; logic [2:0]  arprot;  logic arvalid, arready;
  logic [3:0]  rid;     logic [31:0] rdata;   logic [1:0] rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(14), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] wd [0:31];
  logic [3:0]  ws [0:31];
  logic [31:0] ed [0:15];

  typedef struct {
    logic [31:0] waddr; logic [2:0] wsize; logic [1:0] wburst; logic [7:0] wlen;
    logic [31:0] wdata; logic [3:0] wstrb; logic [1:0] bresp;
    logic [31:0] raddr; logic [2:0] rsize; logic [1:0] rburst;
    logic [31:0] rdata; logic [1:0] rresp;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, awready, 0); chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);   chk({tag, "_arready"}, arready, 0);
    chk({tag, "_rvalid"}, rvalid, 0);   chk({tag, "_rlast"}, rlast, 0);
    chk({tag, "_bid"}, bid, 0);         chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_rid"}, rid, 0);         chk({tag, "_rresp"}, rresp, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] exp_resp, input int bdelay, input bit early_last);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin tick; n++; end
    if (n == 50) chk("aw_timeout", 0, 1);
    tick;
    awvalid = 1'b0;
    chk("wready_latency", wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i];
      wlast = early_last ? (i == 0) : (i == int'(len));
      wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin tick; n++; end
      if (n == 50) chk("w_timeout", 0, 1);
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_latency", bvalid, 1);
    for (int i = 0; i < bdelay; i++) begin
      chk("bvalid_hold", bvalid, 1);
      tick;
    end
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_return", awready, 1);
    $display("WRITE id=%0d addr=%h len=%0d resp=%0d", id, addr, len, exp_resp);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp);
    int n;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin tick; n++; end
    if (n == 50) chk("ar_timeout", 0, 1);
    tick;
    arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, ed[i]);
      chk("rid", rid, id);
      chk("rresp", rresp, exp_resp);
      chk("rlast", rlast, (i == int'(len)));
      tick;
    end
    rready = 1'b0;
    chk("rvalid_drop", rvalid, 0);
    chk("arready_return", arready, 1);
    $display("READ  id=%0d addr=%h len=%0d resp=%0d", id, addr, len, exp_resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, c;
    bit rr [8];

    vecs[0] = '{BASE + 32'h10, 3'd2, 2'b01, 8'd0, 32'hdeadbeef, 4'hf, 2'b00, BASE + 32'h10, 3'd2, 2'b01, 32'hdeadbeef, 2'b00};
    vecs[1] = '{BASE + 32'h20, 3'd2, 2'b01, 8'd0, 32'h12345678, 4'hf, 2'b00, BASE + 32'h20, 3'd2, 2'b01, 32'h12345678, 2'b00};
    vecs[2] = '{BASE + 32'h22, 3'd2, 2'b00, 8'd0, 32'hcafef00d, 4'h3, 2'b00, BASE + 32'h23, 3'd2, 2'b00, 32'h1234f00d, 2'b00};
    vecs[3] = '{BASE + 32'h20, 3'd1, 2'b01, 8'd0, 32'haaaaaaaa, 4'hf, 2'b10, BASE + 32'h20, 3'd2, 2'b01, 32'h1234f00d, 2'b00};
    vecs[4] = '{BASE + 32'h20, 3'd2, 2'b11, 8'd0, 32'haaaaaaaa, 4'hf, 2'b10, BASE + 32'h20, 3'd1, 2'b01, 32'h0, 2'b10};
    vecs[5] = '{BASE + 32'h10000, 3'd2, 2'b01, 8'd0, 32'h55555555, 4'hf, 2'b10, BASE + 32'h10000, 3'd2, 2'b01, 32'h0, 2'b10};
    vecs[6] = '{BASE + 32'hfffc, 3'd2, 2'b01, 8'd0, 32'h0badf00d, 4'hf, 2'b00, BASE + 32'hfffc, 3'd2, 2'b01, 32'h0badf00d, 2'b00};
    vecs[7] = '{BASE - 32'h4, 3'd2, 2'b01, 8'd0, 32'h77777777, 4'hf, 2'b10, BASE + 32'hfffc, 3'd2, 2'b01, 32'h0badf00d, 2'b00};
    vecs[8] = '{BASE + 32'h10, 3'd2, 2'b10, 8'd0, 32'h66666666, 4'hf, 2'b10, BASE + 32'h10, 3'd2, 2'b11, 32'h0, 2'b10};
    vecs[9] = '{BASE + 32'h10, 3'd2, 2'b01, 8'd16, 32'h99999999, 4'hf, 2'b10, BASE + 32'h10, 3'd2, 2'b01, 32'hdeadbeef, 2'b00};

    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0;
    awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0;
    arvalid = 1'b0; rready = 1'b0;

    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0;
    tick;
    chk("post_reset_awready", awready, 1);
    chk("post_reset_arready", arready, 1);
    chk("post_reset_rvalid", rvalid, 0);

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 32; k++) begin wd[k] = vecs[i].wdata; ws[k] = vecs[i].wstrb; end
      write_burst(4'(3 + i), vecs[i].waddr, vecs[i].wlen, vecs[i].wsize, vecs[i].wburst, vecs[i].bresp, 0, 1'b0);
      ed[0] = vecs[i].rdata;
      read_burst(4'(5 + i), vecs[i].raddr, 8'd0, vecs[i].rsize, vecs[i].rburst, vecs[i].rresp);
    end

    // INCR burst with byte strobes merged over a preloaded block
    for (int k = 0; k < 4; k++) begin wd[k] = 32'h11111111; ws[k] = 4'hf; end
    write_burst(4'd1, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 2'b00, 0, 1'b0);
    wd[0] = 32'hA0A0A0A0; ws[0] = 4'hf;
    wd[1] = 32'h222222AA; ws[1] = 4'h1;
    wd[2] = 32'h33CC3333; ws[2] = 4'hc;
    wd[3] = 32'h44444444; ws[3] = 4'hf;
    write_burst(4'd2, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 2'b00, 0, 1'b0);
    ed[0] = 32'hA0A0A0A0; ed[1] = 32'h111111AA; ed[2] = 32'h33CC1111; ed[3] = 32'h44444444;
    read_burst(4'd6, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 2'b00);

    // WRAP from word 2 of an aligned 4-word block, then FIXED
    ed[0] = 32'h33CC1111; ed[1] = 32'h44444444; ed[2] = 32'hA0A0A0A0; ed[3] = 32'h111111AA;
    read_burst(4'd7, BASE + 32'h48, 8'd3, 3'd2, 2'b10, 2'b00);
    ed[0] = 32'h111111AA; ed[1] = 32'h111111AA; ed[2] = 32'h111111AA;
    read_burst(4'd8, BASE + 32'h44, 8'd2, 3'd2, 2'b00, 2'b00);

    // out-of-range AW/AR aliasing onto RAM word 0
    wd[0] = 32'h01020304; ws[0] = 4'hf;
    write_burst(4'd1, BASE, 8'd0, 3'd2, 2'b01, 2'b00, 0, 1'b0);
    wd[0] = 32'hffffffff; wd[1] = 32'hffffffff; ws[0] = 4'hf; ws[1] = 4'hf;
    write_burst(4'd9, 32'h0, 8'd1, 3'd2, 2'b01, 2'b10, 0, 1'b0);
    ed[0] = 32'h01020304;
    read_burst(4'd9, BASE, 8'd0, 3'd2, 2'b01, 2'b00);
    ed[0] = 32'h0; ed[1] = 32'h0; ed[2] = 32'h0;
    read_burst(4'd10, 32'h0, 8'd2, 3'd2, 2'b01, 2'b10);

    // wlast disagreeing with the beat counter
    wd[0] = 32'h1; wd[1] = 32'h2; ws[0] = 4'hf; ws[1] = 4'hf;
    write_burst(4'd4, BASE + 32'h80, 8'd1, 3'd2, 2'b01, 2'b10, 0, 1'b1);

    // B backpressure for 5 cycles
    wd[0] = 32'h5a5a5a5a; ws[0] = 4'hf;
    write_burst(4'd14, BASE + 32'h84, 8'd0, 3'd2, 2'b01, 2'b00, 5, 1'b0);

    // R backpressure: rready 1,0,0,1 then held high
    rr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ed[0] = 32'hA0A0A0A0; ed[1] = 32'h111111AA; ed[2] = 32'h33CC1111; ed[3] = 32'h44444444;
    arid = 4'd11; araddr = BASE + 32'h40; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    chk("bp_arready", arready, 1);
    tick;
    arvalid = 1'b0;
    b = 0; c = 0;
    while (b < 4 && c < 20) begin
      rready = (c < 8) ? rr[c] : 1'b1;
      chk("bp_rvalid", rvalid, 1);
      chk("bp_rdata", rdata, ed[b]);
      chk("bp_rlast", rlast, (b == 3));
      chk("bp_rid", rid, 11);
      tick;
      if (rready) b++;
      c++;
    end
    if (b < 4) chk("bp_timeout", 0, 1);
    rready = 1'b0;
    chk("bp_arready_return", arready, 1);
    $display("READ  id=11 addr=%h len=3 with rready backpressure", BASE + 32'h40);

    // simultaneous AW and AR, then reset in the middle of the read
    awid = 4'd12; awaddr = BASE + 32'h60; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd13; araddr = BASE + 32'h40; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    chk("sim_awready", awready, 1);
    chk("sim_arready", arready, 1);
    tick;
    awvalid = 1'b0; arvalid = 1'b0;
    chk("sim_wready", wready, 1);
    chk("sim_rvalid", rvalid, 1);
    chk("sim_rdata0", rdata, 32'hA0A0A0A0);
    rready = 1'b1;
    tick;
    rready = 1'b0;
    chk("sim_rdata1", rdata, 32'h111111AA);
    rst = 1'b1;
    tick;
    chk_all_zero("midrst");
    rst = 1'b0;
    tick;
    chk("midrst_awready", awready, 1);
    chk("midrst_arready", arready, 1);
    chk("midrst_wready", wready, 0);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_bvalid", bvalid, 0);
    tick;
    chk("midrst_no_b", bvalid, 0);
    chk("midrst_no_r", rvalid, 0);
    $display("RESET mid-burst: AW id=12 and AR id=13 aborted");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3-style slave responder backed by an on-chip word-addressed RAM, the far end of the core's 32-bit AXI master bus. It accepts read and write bursts (FIXED/INCR/WRAP, 1–16 beats) and returns beat data and responses with correct IDs. It is intended for simulation benches and FPGA bring-up as the memory behind the core's `araddr`/`awaddr`/... port set. The read and write channels run independent state machines, each with one outstanding transaction.

## Interface
Parameters:
- `MEM_AW`, 14: RAM word-address width (depth = 2^MEM_AW 32-bit words).
- `BASE_ADDR`, 32'h1c00_0000: byte base address; must be aligned to 4·2^MEM_AW.

Ports:
- Clock and reset (one clock; reset is synchronous and active-high):
  - `clk` in 1: clock.
  - `rst` in 1: synchronous active-high reset.
- Write address channel:
  - `awid` in 4; `awaddr` in 32; `awlen` in 8; `awsize` in 3; `awburst` in 2.
  - `awlock` in 2; `awcache` in 4; `awprot` in 3: all three ignored.
  - `awvalid` in 1; `awready` out 1.
- Write data channel:
  - `wid` in 4: ignored; `wdata` in 32; `wstrb` in 4; `wlast` in 1.
  - `wvalid` in 1; `wready` out 1.
- Write response channel:
  - `bid` out 4; `bresp` out 2; `bvalid` out 1; `bready` in 1.
- Read address channel:
  - `arid` in 4; `araddr` in 32; `arlen` in 8; `arsize` in 3; `arburst` in 2.
  - `arlock` in 2; `arcache` in 4; `arprot` in 3: all three ignored.
  - `arvalid` in 1; `arready` out 1.
- Read data channel:
  - `rid` out 4; `rdata` out 32; `rresp` out 2; `rlast` out 1; `rvalid` out 1; `rready` in 1.

## Operation
- Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: `awready`=1. On `awvalid&&awready`, latch id, address, len, burst and the error flag, then go to W_DATA.
  - W_DATA: `wready`=1. Each `wvalid` beat writes the byte lanes selected by `wstrb` to mem[addr] (no write when the error flag is set), then advances the address and the beat counter. On the beat where the counter equals len, go to W_RESP. The slave's counter decides the end of the burst; `wlast` is not used for that. A mismatch between `wlast` and the counter sets SLVERR.
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=00 OKAY or 10 SLVERR. Hold until `bready`, then go to W_IDLE.
- Read FSM, states R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: `arready`=1. On handshake, latch the fields and go to R_DATA.
  - R_DATA: `rvalid`=1, `rid`=latched id, `rdata`=mem[addr] (0 on error), `rresp` as for the write side, `rlast`=(beat==len).
  - On `rvalid&&rready`: if `rlast`, go to R_IDLE; otherwise advance the address.
  - `rdata` and `rlast` stay stable while `rready`=0.
- Error flag is set when any of the following holds:
  - the address is outside [BASE_ADDR, BASE_ADDR + 4·2^MEM_AW);
  - size ≠ 3'b010;
  - burst = 2'b11;
  - burst = WRAP with len not in {1,3,7,15};
  - len > 15.
  - On error, the full len+1 beats are still consumed or produced.
- Address advance, in words:
  - FIXED: unchanged.
  - INCR: +1, wrapping modulo 2^MEM_AW.
  - WRAP: low log2(len+1) bits increment modulo len+1; upper bits held.
- Word index = addr[MEM_AW+1:2]. Unaligned awaddr/araddr low bits are ignored.
- Same-cycle read and write to the same word: the read beat shows the old data. The new data is visible on the next read beat.
- RAM contents are not reset.

## Timing
- During reset and the cycle it is asserted, all outputs are 0: `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast`, and `bid`/`bresp`/`rid`/`rresp`/`rdata`.
- The first cycle after `rst` deasserts: `awready`=`arready`=1.
- Write latency:
  - `wready` rises the cycle after the AW handshake.
  - One beat is accepted per cycle.
  - `bvalid` rises the cycle after the last W beat.
  - `awready` returns the cycle after the B handshake.
- Read latency:
  - `rvalid` rises the cycle after the AR handshake.
  - Beats are back-to-back when `rready` is held high.
  - `arready` returns the cycle after the `rlast` handshake.
- The two FSMs are fully concurrent. An AW and an AR handshake in the same cycle are both accepted.
- Reset mid-burst aborts both FSMs to IDLE next cycle. No B or R is ever issued for the aborted transaction.
- `awready`/`arready` never depend combinationally on `awvalid`/`arvalid`. No output has a combinational path from any input.

## Test plan
- Single write, then single read: AW addr=BASE+0x10, id=3, len=0, size=2, INCR; W data=0xdeadbeef, strb=0xf. Expect B id=3, resp=00. AR to the same address, id=5, returns rdata=0xdeadbeef, rid=5, rlast=1, rresp=00, with `rvalid` one cycle after the AR handshake.
- INCR 4-beat write with strb pattern 0xf, 0x1, 0xc, 0xf over preloaded 0x11111111 words, then a 4-beat read. Expect the merged words, e.g. beat1 = 0x111111AA for data 0x…AA. `rlast` only on beat 3.
- WRAP len=3 read starting at word 2 of a 4-word-aligned block. Expect word order 2, 3, 0, 1.
- Out-of-range AW (addr=0x0) with len=1: two W beats accepted, RAM unchanged, bresp=10. Out-of-range AR with len=2: three beats of rdata=0, rresp=10.
- Backpressure: `rready` toggles 1, 0, 0, 1 during an INCR len=3 read, and `bready` is held low for 5 cycles. Expect R outputs stable while stalled, and `bvalid` held until the handshake.
- Simultaneous AW and AR in the same cycle, then `rst` asserted mid-read. Expect both handshakes accepted, then all outputs 0 and `awready`=`arready`=1 the cycle after reset deasserts.
